ifu_fetch: RTL

//  Instruction fetch unit; upstream producer of the IF/ID handshake that the decode stage consumes.

---
 rtl/ifu_fetch_pkg.sv | 27 ++
 rtl/ifu_fetch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module      : ifu_fetch_pkg
// Description : FSM encodings and reset/fault constants shared by the fetch
//               unit, decode and the trap logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_HOLD = 2'd3;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] c_EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] c_INST_BYTES       = 32'd4;

    // Instructions are word aligned; the low two bits of any target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module      : ifu_fetch
// Description : Single-outstanding instruction fetch unit. Issues one read at
//               a time, buffers the word and presents {pc, inst} to decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_RESET_PC_DEFAULT,
    parameter logic [31:0] FAULT_INST = c_EBREAK_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_kill;
    logic [31:0] r_inst_buf;
    logic [31:0] r_pc_buf;
    logic        r_fault_buf;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_req_addr_nxt;
    logic        w_kill_nxt;
    logic        w_buf_load;
    logic [31:0] w_redirect_tgt;
    logic [31:0] w_pc_inc;
    logic        w_req_fire;

    assign w_redirect_tgt = align_pc(redirect_pc);
    assign w_pc_inc       = r_pc + c_INST_BYTES;
    assign w_req_fire     = mem_req_valid && mem_req_ready;

    assign mem_req_valid  = (r_state == c_ST_REQ);
    assign mem_req_addr   = r_req_addr;
    assign mem_resp_ready = (r_state == c_ST_WAIT);
    // A redirect in HOLD must never let the buffered (now stale) word handshake.
    assign out_valid      = (r_state == c_ST_HOLD) && !redirect_valid;
    assign out_pc         = r_pc_buf;
    assign out_inst       = r_inst_buf;
    assign out_fault      = r_fault_buf;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_kill_nxt     = r_kill;
        w_buf_load     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_state_nxt = c_ST_REQ;
            end
            c_ST_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = c_ST_WAIT;
                end
                // A pending request keeps its address; its response is dropped instead.
                if (redirect_valid) begin
                    w_pc_nxt   = w_redirect_tgt;
                    w_kill_nxt = 1'b1;
                end
            end
            c_ST_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_tgt;
                    if (mem_resp_valid) begin
                        w_kill_nxt     = 1'b0;
                        w_req_addr_nxt = w_redirect_tgt;
                        w_state_nxt    = c_ST_REQ;
                    end else begin
                        w_kill_nxt = 1'b1;
                    end
                end else if (mem_resp_valid) begin
                    if (r_kill) begin
                        w_kill_nxt     = 1'b0;
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = c_ST_REQ;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = c_ST_HOLD;
                    end
                end
            end
            c_ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt       = w_redirect_tgt;
                    w_req_addr_nxt = w_redirect_tgt;
                    w_state_nxt    = c_ST_REQ;
                end else if (out_ready) begin
                    w_pc_nxt       = w_pc_inc;
                    w_req_addr_nxt = w_pc_inc;
                    w_state_nxt    = c_ST_REQ;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_kill     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_kill     <= w_kill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_buf  <= 32'd0;
            r_pc_buf    <= 32'd0;
            r_fault_buf <= 1'b0;
        end else if (w_buf_load) begin
            r_inst_buf  <= mem_resp_err ? FAULT_INST : mem_resp_data;
            r_pc_buf    <= r_pc;
            r_fault_buf <= mem_resp_err;
        end
    end

endmodule

`default_nettype wire
